// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared constants and chord FSM state type for the key debouncer
package key_pkg;

  localparam int MAX_KEYS            = 8;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  typedef enum logic {
    IDLE,
    GATHER
  } chord_state_e;

endpackage

// File: rtl/key_debounce_chan.sv
// rtl/key_debounce_chan.sv - one key: two-flop sync, stability counter, level and pulses
// Auto-repeat of press pulses is built only when KEY_REPEAT_EN is defined.
module key_debounce_chan #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic level_d_o,
  output logic press_d_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          raw_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);
  logic [RW-1:0] rpt_q, rpt_d;
`endif

  assign raw_s = ~sync2_q;

  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (raw_s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d     = '0;
      level_d   = raw_s;
      press_d   = raw_s;
      release_d = ~raw_s;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
`ifdef KEY_REPEAT_EN
    // Reloading to DELAY-PERIOD makes every later repeat one PERIOD apart.
    rpt_d = rpt_q;
    if (!level_q || !level_d) begin
      rpt_d = '0;
    end else if (rpt_q == RPT_LAST) begin
      rpt_d   = RPT_RELOAD;
      press_d = 1'b1;
    end else begin
      rpt_d = rpt_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= key_n_i;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_d;
    end
  end
`endif

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign level_d_o = level_d;
  assign press_d_o = press_d;

endmodule

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - per-key debounce channels plus chord gesture tracker
// Define KEY_REPEAT_EN to enable auto-repeat press pulses in every channel.
module key_debouncer
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                clock_50,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_n_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                chord_valid,
  output logic [NUM_KEYS-1:0] chord_mask
);

  logic [NUM_KEYS-1:0] level_d;
  logic [NUM_KEYS-1:0] press_d;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk_i    (clock_50),
      .rst_ni   (reset_n),
      .key_n_i  (key_n_in[k]),
      .level_o  (key_level[k]),
      .press_o  (key_press[k]),
      .release_o(key_release[k]),
      .level_d_o(level_d[k]),
      .press_d_o(press_d[k])
    );
  end

  chord_state_e        state_q, state_d;
  logic [NUM_KEYS-1:0] acc_q, acc_d;
  logic                valid_q, valid_d;
  logic [NUM_KEYS-1:0] mask_q, mask_d;

  // Channel next-state signals are used so chord_valid lands with the final release.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    valid_d = 1'b0;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        if (|press_d) begin
          acc_d   = press_d;
          state_d = GATHER;
        end
      end
      GATHER: begin
        acc_d = acc_q | press_d;
        if (level_d == '0) begin
          valid_d = 1'b1;
          mask_d  = acc_q | press_d;
          acc_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      valid_q <= 1'b0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      mask_q  <= mask_d;
    end
  end

  assign chord_valid = valid_q;
  assign chord_mask  = mask_q;

endmodule

// File: tb/tb_key_debouncer.sv
// tb/tb_key_debouncer.sv - directed table-driven bench for key_debouncer (honours KEY_REPEAT_EN)
module tb_key_debouncer;

  logic       clock_50 = 1'b0;
  logic       reset_n  = 1'b0;
  logic [1:0] key_n_in = 2'b11;
  logic [1:0] key_level, key_press, key_release, chord_mask;
  logic       chord_valid;

  int checks   = 0;
  int failures = 0;

  key_debouncer #(
    .NUM_KEYS       (2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clock_50   (clock_50),
    .reset_n    (reset_n),
    .key_n_in   (key_n_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .chord_valid(chord_valid),
    .chord_mask (chord_mask)
  );

  always #5 clock_50 = ~clock_50;

  typedef struct {
    logic [1:0] key_n;
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] rel;
    logic       valid;
    logic [1:0] mask;
    int         rep;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] kn, input logic [1:0] lv, input logic [1:0] pr,
                     input logic [1:0] rl, input logic vl, input logic [1:0] mk, input int rep);
    vec_t v;
    v.key_n = kn; v.level = lv; v.press = pr; v.rel = rl; v.valid = vl; v.mask = mk; v.rep = rep;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clock_50);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [1:0] lv, input logic [1:0] pr,
                            input logic [1:0] rl, input logic vl, input logic [1:0] mk);
    check(name, {23'd0, key_level, key_press, key_release, chord_valid, chord_mask},
          {23'd0, lv, pr, rl, vl, mk});
  endtask

  initial begin
    int press_at, press_cnt, valid_cnt, valid_at;
    logic [1:0] valid_mask;
    int offs[$];
    int exp_offs[$];

    // idx0 is the first edge after the input change: a clean edge shows at idx5
    add(2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1);
    add(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 4);
    add(2'b10, 2'b01, 2'b01, 2'b00, 1'b0, 2'b00, 1);
    add(2'b11, 2'b11, 2'b10, 2'b00, 1'b0, 2'b00, 1);
    add(2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 3);
    add(2'b11, 2'b01, 2'b00, 2'b10, 1'b0, 2'b00, 1);
    add(2'b11, 2'b00, 2'b00, 2'b01, 1'b1, 2'b11, 1);
    add(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 2'b11, 3);
    // three-cycle glitches never reach the terminal count
    add(2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 2'b11, 3);
    add(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 2'b11, 3);
    add(2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 2'b11, 3);
    add(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 2'b11, 6);
    // both keys together
    add(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b11, 5);
    add(2'b00, 2'b11, 2'b11, 2'b00, 1'b0, 2'b11, 1);
    add(2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 2'b11, 5);
    add(2'b11, 2'b00, 2'b00, 2'b11, 1'b1, 2'b11, 1);
    add(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 2'b11, 3);
    // key1 alone
    add(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2'b11, 5);
    add(2'b01, 2'b10, 2'b10, 2'b00, 1'b0, 2'b11, 1);
    add(2'b11, 2'b10, 2'b00, 2'b00, 1'b0, 2'b11, 5);
    add(2'b11, 2'b00, 2'b00, 2'b10, 1'b1, 2'b10, 1);
    add(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 2'b10, 3);

    repeat (3) tick();
    check_outs("reset_hold", 2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
    reset_n = 1'b1;
    tick();
    check_outs("after_reset", 2'b00, 2'b00, 2'b00, 1'b0, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int r = 0; r < vecs[i].rep; r++) begin
        key_n_in = vecs[i].key_n;
        tick();
        check_outs($sformatf("vec%0d_r%0d", i, r), vecs[i].level, vecs[i].press,
                   vecs[i].rel, vecs[i].valid, vecs[i].mask);
      end
    end

    // reset in the middle of a key1 gesture
    key_n_in = 2'b01;
    repeat (6) tick();
    check("mid_level_before_reset", {30'd0, key_level}, 32'h2);
    repeat (2) tick();
    #2 reset_n = 1'b0;
    #1;
    check_outs("async_reset_clears", 2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
    valid_cnt = 0;
    repeat (2) begin
      tick();
      if (chord_valid) valid_cnt++;
    end
    reset_n = 1'b1;
    press_at = 0; press_cnt = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (chord_valid) valid_cnt++;
      if (key_press != 2'b00) begin
        press_cnt++;
        if (key_press == 2'b10 && press_at == 0) press_at = k;
      end
    end
    check("repress_edge", press_at, 6);
    check("repress_count", press_cnt, 1);
    check("no_chord_over_reset", valid_cnt, 0);
    check("mask_reset", {30'd0, chord_mask}, 32'h0);

    key_n_in = 2'b11;
    valid_cnt = 0; valid_at = 0; valid_mask = 2'b00;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (chord_valid) begin
        valid_cnt++;
        valid_at = k;
        valid_mask = chord_mask;
      end
    end
    check("post_reset_chord_count", valid_cnt, 1);
    check("post_reset_chord_edge", valid_at, 6);
    check("post_reset_chord_mask", {30'd0, valid_mask}, 32'h2);

    // key0 held 30 cycles past its debounced press
    key_n_in = 2'b10;
    for (int k = 1; k <= 36; k++) begin
      tick();
      if (key_press[0]) offs.push_back(k);
      if (key_press[1]) check("no_press_key1", {31'd0, key_press[1]}, 32'h0);
    end
    exp_offs.push_back(0);
`ifdef KEY_REPEAT_EN
    for (int t = 10; t <= 28; t += 3) exp_offs.push_back(t);
`endif
    check("repeat_pulse_count", offs.size(), exp_offs.size());
    if (offs.size() > 0) check("first_press_edge", offs[0], 6);
    for (int i = 0; i < offs.size() && i < exp_offs.size(); i++)
      check($sformatf("repeat_off%0d", i), offs[i] - offs[0], exp_offs[i]);

    key_n_in = 2'b11;
    valid_cnt = 0; valid_mask = 2'b00;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (chord_valid) begin
        valid_cnt++;
        valid_mask = chord_mask;
      end
    end
    check("hold_chord_count", valid_cnt, 1);
    check("hold_chord_mask", {30'd0, valid_mask}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
